// File: rtl/core_pkg.sv
// Shared core-wide constants for the RV32 (npc) datapath.
//   XLEN       : integer register / datapath width
//   REG_ADDR_W : architectural register index width
//   REG_ZERO   : index of the hardwired-zero register x0
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/write_addr_decoder.sv
// Write-port address decoder for the integer register file.
// Turns the destination index into one-hot per-register write enables,
// gated by wen. The enable for x0 is always low, so writes to x0 vanish.
//   wen   : write enable
//   waddr : destination register index (rd)
//   we    : one-hot (or all-zero) per-register write enables
module write_addr_decoder
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  output logic [NUM_REGS-1:0]   we
);

  always_comb begin
    we = '0;
    if (wen) begin
      we[waddr] = 1'b1;
    end
    we[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// General-purpose integer register file for the single-cycle RV32 core.
// Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
// x0 has no storage and always reads zero. Reads see the pre-edge value
// when the same register is written in that cycle (no write-to-read bypass).
//   clk            : clock, state updates on rising edge
//   reset          : synchronous active-high reset, clears x1..x31, beats wen
//   wen/waddr/wdata: write port
//   raddr1/rdata1  : read port 1 (src1)
//   raddr2/rdata2  : read port 2 (src2 / store data)
module register_file
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic [NUM_REGS-1:0]   we;
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  write_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_write_addr_decoder (
    .wen   (wen),
    .waddr (waddr),
    .we    (we)
  );

  always_comb begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[ADDR_WIDTH'(i)] = regs_q[ADDR_WIDTH'(i)];
      if (we[ADDR_WIDTH'(i)]) begin
        regs_d[ADDR_WIDTH'(i)] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_q[ADDR_WIDTH'(i)] <= '0;
      end else begin
        regs_q[ADDR_WIDTH'(i)] <= regs_d[ADDR_WIDTH'(i)];
      end
    end
  end

  // Index 0 never matches the loop, so x0 falls through to the zero default.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (raddr1 == ADDR_WIDTH'(i)) begin
        rdata1 = regs_q[ADDR_WIDTH'(i)];
      end
      if (raddr2 == ADDR_WIDTH'(i)) begin
        rdata2 = regs_q[ADDR_WIDTH'(i)];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a table of directed vectors, each
// checked just before the rising edge that applies it, plus hand sequences
// for same-cycle address changes, a full write/read sweep and a final reset.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int total;
  int bad;

  register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reset;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp1;  // rdata1 expected before this vector's edge
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [12];
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    //               rst  wen  waddr  wdata          ra1    ra2    exp1           exp2
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 5'd10, 32'h80000004, 5'd10, 5'd10, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd10, 5'd10, 32'h80000004, 32'h80000004};
    vecs[5]  = '{1'b0, 1'b0, 5'd3,  32'h12345678, 5'd0,  5'd10, 32'h0,        32'h80000004};
    vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd3,  5'd0,  32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h11111111, 32'h11111111};
    vecs[8]  = '{1'b1, 1'b1, 5'd4,  32'hA5A5A5A5, 5'd7,  5'd4,  32'h22222222, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd4,  5'd7,  32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 1'b0, 5'd1,  32'h0,        5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};

    // Power-up reset, then every index must read zero on both ports.
    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), rdata1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rdata2, 32'h0);
    end

    // Table vectors: drive at negedge, check pre-edge reads, edge applies.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      reset  = vecs[v].reset;
      wen    = vecs[v].wen;
      waddr  = vecs[v].waddr;
      wdata  = vecs[v].wdata;
      raddr1 = vecs[v].raddr1;
      raddr2 = vecs[v].raddr2;
      #1;
      check($sformatf("vec%0d_rd1", v), rdata1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), rdata2, vecs[v].exp2);
    end

    // Read ports follow address changes with no clock edge in between.
    @(negedge clk);
    reset = 1'b0; wen = 1'b0;
    raddr1 = 5'd1;  #1; check("comb_rd1_x1", rdata1, 32'h00000001);
    raddr1 = 5'd31; #1; check("comb_rd1_x31", rdata1, 32'hCAFEF00D);
    raddr1 = 5'd0;  #1; check("comb_rd1_x0", rdata1, 32'h0);
    raddr2 = 5'd7;  #1; check("comb_rd2_x7", rdata2, 32'h0);

    // Sweep: write a distinct pattern to every index (x0 included) and
    // read all back through both ports against a local model.
    model[0] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wen   = 1'b1;
      waddr = 5'(i);
      wdata = 32'h5A000000 | (32'(i) << 8) | (32'(i) ^ 32'h3C);
      if (i != 0) model[i] = wdata;
    end
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_x%0d", i), rdata1, model[i]);
      check($sformatf("sweep_rd2_x%0d", 31 - i), rdata2, model[31 - i]);
    end

    // Reset mid-operation clears everything again.
    @(negedge clk);
    reset = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'h0BADF00D;
    @(negedge clk);
    reset = 1'b0; wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(i);
      #1;
      check($sformatf("rst2_rd1_x%0d", i), rdata1, 32'h0);
      check($sformatf("rst2_rd2_x%0d", i), rdata2, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
